// File: rtl/demux_pkg.sv
// Shared constants for the 2:1 demux / deserializer: default word width,
// counter-width helper and lane-select encoding.
package demux_pkg;

  localparam int DEF_WIDTH = 8;

  // Select encoding, matching the transmit mux (out = sl ? b : a)
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Bit-counter width for a lane of w bits; never narrower than one bit
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/deser_lane.sv
// One deserializer lane: shifts in bits MSB-first while enabled, and emits a
// completed word with a one-cycle valid pulse every WIDTH accepted bits.
module deser_lane
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             shift_en,
  input  logic             clr,
  output logic             bit_q,
  output logic [WIDTH-1:0] word,
  output logic             valid
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift;
  logic [CNT_W-1:0] cnt;

  // Shift/count state; clr drops the partial word but keeps the last word and bit
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      cnt   <= '0;
      bit_q <= 1'b0;
      word  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clr) begin
        shift <= '0;
        cnt   <= '0;
      end else if (shift_en) begin
        bit_q <= bit_in;
        shift <= {shift[WIDTH-2:0], bit_in};
        if (cnt == LAST) begin
          word  <= {shift[WIDTH-2:0], bit_in};
          valid <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/demux_deser2.sv
// Receive side of the 2:1 bit mux: routes each sampled bit to lane A or B by
// sl and deserializes each lane independently into WIDTH-bit words.
module demux_deser2
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             din,
  input  logic             sl,
  input  logic             en,
  input  logic             sync_clr,
  output logic             out_a,
  output logic             out_b,
  output logic [WIDTH-1:0] word_a,
  output logic [WIDTH-1:0] word_b,
  output logic             valid_a,
  output logic             valid_b
);

  logic shift_en_a;
  logic shift_en_b;

  // Select decode: a clear cycle never shifts either lane
  always_comb begin
    shift_en_a = en & (sl == CH_A) & ~sync_clr;
    shift_en_b = en & (sl == CH_B) & ~sync_clr;
  end

  deser_lane #(.WIDTH(WIDTH)) u_lane_a (
    .clock    (clock),
    .rst_n    (rst_n),
    .bit_in   (din),
    .shift_en (shift_en_a),
    .clr      (sync_clr),
    .bit_q    (out_a),
    .word     (word_a),
    .valid    (valid_a)
  );

  deser_lane #(.WIDTH(WIDTH)) u_lane_b (
    .clock    (clock),
    .rst_n    (rst_n),
    .bit_in   (din),
    .shift_en (shift_en_b),
    .clr      (sync_clr),
    .bit_q    (out_b),
    .word     (word_b),
    .valid    (valid_b)
  );

endmodule

// File: tb/tb_demux_deser2.sv
// Directed bench for demux_deser2 (WIDTH=8) with hand-computed expectations.
module tb_demux_deser2;

  logic       clock;
  logic       rst_n;
  logic       din;
  logic       sl;
  logic       en;
  logic       sync_clr;
  logic       out_a;
  logic       out_b;
  logic [7:0] word_a;
  logic [7:0] word_b;
  logic       valid_a;
  logic       valid_b;

  int vectors = 0;
  int errors  = 0;

  demux_deser2 #(.WIDTH(8)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .din      (din),
    .sl       (sl),
    .en       (en),
    .sync_clr (sync_clr),
    .out_a    (out_a),
    .out_b    (out_b),
    .word_a   (word_a),
    .word_b   (word_b),
    .valid_a  (valid_a),
    .valid_b  (valid_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, wait for the edge, settle
  task automatic step(input logic d, input logic s, input logic e, input logic c);
    din = d; sl = s; en = e; sync_clr = c;
    @(posedge clock);
    #1;
  endtask

  // Send n bits (MSB of the n-bit field first) on lane s. If pulse is set the
  // lane's valid must rise exactly after the last bit, otherwise never.
  task automatic send(input string tag, input logic s, input logic [15:0] bits,
                      input int n, input logic pulse);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = bits[n-1-i];
      step(b, s, 1'b1, 1'b0);
      if (s == 1'b0) begin
        chk({tag, " out_a"}, {7'b0, out_a}, {7'b0, b});
        chk({tag, " valid_a"}, {7'b0, valid_a}, {7'b0, (pulse && i == n-1)});
        chk({tag, " valid_b"}, {7'b0, valid_b}, 8'h00);
      end else begin
        chk({tag, " out_b"}, {7'b0, out_b}, {7'b0, b});
        chk({tag, " valid_b"}, {7'b0, valid_b}, {7'b0, (pulse && i == n-1)});
        chk({tag, " valid_a"}, {7'b0, valid_a}, 8'h00);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_a"},   {7'b0, out_a},   8'h00);
    chk({tag, " out_b"},   {7'b0, out_b},   8'h00);
    chk({tag, " word_a"},  word_a,          8'h00);
    chk({tag, " word_b"},  word_b,          8'h00);
    chk({tag, " valid_a"}, {7'b0, valid_a}, 8'h00);
    chk({tag, " valid_b"}, {7'b0, valid_b}, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; sl = 1'b0; en = 1'b0; sync_clr = 1'b0;

    // Reset state, including with inputs active while held in reset
    #3;
    chk_all_zero("rst");
    din = 1'b1; en = 1'b1;
    @(posedge clock); #1;
    chk_all_zero("rst_hold");
    en = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;

    // 1: eight bits on A -> B2
    send("t1", 1'b0, 16'h00B2, 8, 1'b1);
    chk("t1 word_a", word_a, 8'hB2);
    chk("t1 out_b", {7'b0, out_b}, 8'h00);
    chk("t1 word_b", word_b, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1 valid_a drop", {7'b0, valid_a}, 8'h00);
    chk("t1 out_a hold", {7'b0, out_a}, 8'h00);

    // 2: interleave in nibbles
    send("t2a0", 1'b0, 16'h000A, 4, 1'b0);
    send("t2b0", 1'b1, 16'h000C, 4, 1'b0);
    send("t2a1", 1'b0, 16'h0005, 4, 1'b1);
    chk("t2 word_a", word_a, 8'hA5);
    chk("t2 word_b mid", word_b, 8'h00);
    send("t2b1", 1'b1, 16'h0003, 4, 1'b1);
    chk("t2 word_b", word_b, 8'hC3);
    chk("t2 word_a hold", word_a, 8'hA5);

    // 3: back-to-back words on A
    send("t3w0", 1'b0, 16'h00F0, 8, 1'b1);
    chk("t3 word_a0", word_a, 8'hF0);
    send("t3w1", 1'b0, 16'h003C, 8, 1'b1);
    chk("t3 word_a1", word_a, 8'h3C);

    // 4: stall on B with en=0 and toggling din
    send("t4p0", 1'b1, 16'h0019, 5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(i[0], 1'b1, 1'b0, 1'b0);
      chk("t4 stall valid_b", {7'b0, valid_b}, 8'h00);
      chk("t4 stall valid_a", {7'b0, valid_a}, 8'h00);
      chk("t4 stall out_b", {7'b0, out_b}, 8'h01);
    end
    send("t4p1", 1'b1, 16'h0003, 3, 1'b1);
    chk("t4 word_b", word_b, 8'hCB);
    chk("t4 word_a hold", word_a, 8'h3C);

    // 5: sync_clr discards the partial A word and its own din bit
    send("t5p", 1'b0, 16'h0016, 5, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5 clr valid_a", {7'b0, valid_a}, 8'h00);
    chk("t5 clr out_a", {7'b0, out_a}, 8'h00);
    chk("t5 clr word_a", word_a, 8'h3C);
    chk("t5 clr word_b", word_b, 8'hCB);
    send("t5w", 1'b0, 16'h0081, 8, 1'b1);
    chk("t5 word_a", word_a, 8'h81);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5 single pulse", {7'b0, valid_a}, 8'h00);

    // 6: asynchronous reset mid-word
    send("t6p", 1'b0, 16'h003F, 6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6 async");
    @(negedge clock);
    rst_n = 1'b1;
    send("t6w", 1'b0, 16'h005A, 8, 1'b1);
    chk("t6 word_a", word_a, 8'h5A);
    chk("t6 word_b", word_b, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/demux_deser2.md
Name: demux_deser2

Overview:
- Receive-side counterpart of the team's 2:1 bit mux (out = sl ? b : a).
- Takes the single multiplexed bit stream plus its select line and routes each bit back to channel A (sl=0) or channel B (sl=1).
- Each channel is deserialized independently into WIDTH-bit words, each with a one-cycle valid strobe.
- Sits directly after the mux on the same clock, so recovered data can be checked against the original a/b streams.

Parameters:
- WIDTH, 8, bits per recovered word per channel; legal range is WIDTH >= 2.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  1  multiplexed serial bit (the mux output).
- sl  in  1  channel select accompanying din: 0 = channel A, 1 = channel B.
- en  in  1  bit-valid; din/sl are sampled only when en=1.
- sync_clr  in  1  synchronous clear of both lanes' partial words.
- out_a  out  1  registered demux output, channel A (last bit routed to A).
- out_b  out  1  registered demux output, channel B.
- word_a  out  WIDTH  last completed channel-A word, MSB = first bit received.
- word_b  out  WIDTH  last completed channel-B word.
- valid_a  out  1  one-cycle pulse: word_a updated this cycle.
- valid_b  out  1  one-cycle pulse: word_b updated this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-word):
  - out_a, out_b, word_a, word_b, valid_a, valid_b all go to 0.
  - Shift registers and bit counters go to 0.
- Sampling edge with en=1, sync_clr=0, sl=0:
  - out_a <= din.
  - Lane A shifts left: shift_a <= {shift_a[WIDTH-2:0], din}.
  - cnt_a increments.
  - Lane B, out_b and word_b hold.
- Same edge with sl=1: mirror image, lane B is active and lane A holds.
- Word completion:
  - When the active lane's counter equals WIDTH-1 on a sampling edge, that lane loads {shift[WIDTH-2:0], din} into word_x on that edge.
  - valid_x is 1 for the following cycle only.
  - The counter wraps to 0.
  - Latency: word_x/valid_x are visible 1 clock after the edge that sampled the last bit.
- valid_x is 0 in every cycle except the completion cycle. There is no back-pressure; the consumer must capture word_x while valid_x=1 or before the next completion.
- Counter width: $clog2(WIDTH). Wrap is explicit at WIDTH-1, so non-power-of-2 WIDTH works.
- sl may change on any cycle. Each lane keeps its partial word and counter while the other lane is active, so interleaving at any granularity reassembles correctly.
- en=0: no state changes and no valid pulses. A partial word resumes when en returns to 1.
- sync_clr=1:
  - Takes priority over en.
  - Both counters and shift registers go to 0, and valid_a/valid_b are 0 on the next cycle.
  - word_a, word_b, out_a and out_b hold.
  - The bit on din that cycle is discarded.
- Deassertion of rst_n is sampled with the clock. The first sampling edge after release counts as bit 0.

Decomposition:
- Package demux_pkg:
  - Constant DEF_WIDTH = 8.
  - Localparam helper for the counter width.
  - Lane-select encoding constants CH_A = 1'b0, CH_B = 1'b1.
- Sub-module deser_lane (ports: clock, rst_n, bit_in, shift_en, clr, bit_q, word, valid), instantiated twice.
- The top level contains only the select decode (shift_en_a = en & ~sl & ~sync_clr, and the B counterpart) plus lane wiring.

Test Plan:
1. sl=0, en=1, din=1,0,1,1,0,0,1,0 over 8 edges -> word_a=8'hB2 and valid_a=1 for exactly one cycle after the 8th edge; valid_b=0 throughout; out_a tracks din one clock late; out_b stays 0.
2. Interleave in blocks of 4 bits: A=1010, B=1100, A=0101, B=0011 -> word_a=8'hA5 with valid_a pulse after the 12th edge; word_b=8'hC3 with valid_b pulse after the 16th edge.
3. Send 16 consecutive bits on A (0xF0 then 0x3C) -> two valid_a pulses 8 cycles apart, with word_a=8'hF0 then 8'h3C; no gap cycles required.
4. Send 5 bits on B, then en=0 for 3 cycles with din toggling, then 3 more bits (bit sequence 1,1,0,0,1 | 0,1,1) -> word_b=8'hCB; no valid pulse during the en=0 cycles.
5. Send 5 bits on A, pulse sync_clr with din=1, then send 8 bits 0x81 -> word_a=8'h81 with a single valid_a; the earlier partial word never appears.
6. Send 6 bits of 0xFF on A, then assert rst_n=0 between edges -> all outputs read 0 before the next edge; after release, 8 bits 0x5A -> word_a=8'h5A.
